// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the CNT_W-bit duty value from a PWM line whose
// period is 2^CNT_W clocks, with valid strobe, lock and error status.
// Ports: clk, rst_n (async assert, sync deassert), pwm_in (async line),
//   duty_out (held value), duty_valid (1-cycle strobe on update),
//   locked (consecutive good measurements), err (1-cycle strobe, bad period).
// Option: PWM_DEGLITCH_EN adds a 3-sample majority-free agreement filter.
module pwm_duty_decoder #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic             duty_valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W:0] PERIOD   = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] IDLE_TOP = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] CNT_MAX  = {(CNT_W+1){1'b1}};
  localparam logic [CNT_W:0] ONE      = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DUTY_MAX = {CNT_W{1'b1}};

  // reset release is re-timed to clk; assertion stays asynchronous
  logic [1:0] r_rst_q;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_q <= '0;
    else        r_rst_q <= {r_rst_q[0], 1'b1};
  end

  assign w_rst_n = r_rst_q[1];

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_spwm;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_DEGLITCH_EN
  // level only moves once the synchronizer has agreed for 3 samples
  logic [1:0] r_hist;
  logic       r_filt;
  logic       w_agree;

  assign w_agree = (w_sync == r_hist[0]) && (w_sync == r_hist[1]);
  assign w_spwm  = w_agree ? w_sync : r_filt;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], w_sync};
      r_filt <= w_spwm;
    end
  end
`else
  assign w_spwm = w_sync;
`endif

  // edge pulses are registered; r_prev is the level aligned with them
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_spwm;
      r_rise <= w_spwm & ~r_prev;
      r_fall <= ~w_spwm & r_prev;
    end
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W:0]   r_per;
  logic [CNT_W:0]   r_hi;
  logic [CNT_W:0]   r_idle;
  logic [CNT_W:0]   w_per_nx;
  logic [CNT_W:0]   w_hi_nx;
  logic [CNT_W:0]   w_idle_nx;
  logic [CNT_W:0]   w_per_inc;
  logic [CNT_W:0]   w_hi_inc;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] w_duty_nx;
  logic             r_valid;
  logic             r_lock;
  logic             r_err;
  logic             w_valid_nx;
  logic             w_lock_nx;
  logic             w_err_nx;

  assign w_per_inc = (r_per == CNT_MAX) ? r_per : r_per + 1'b1;
  assign w_hi_inc  = (r_hi  == CNT_MAX) ? r_hi  : r_hi  + 1'b1;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= SEEK;
      r_per   <= '0;
      r_hi    <= '0;
      r_idle  <= '0;
      r_duty  <= '0;
      r_valid <= 1'b0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_per   <= w_per_nx;
      r_hi    <= w_hi_nx;
      r_idle  <= w_idle_nx;
      r_duty  <= w_duty_nx;
      r_valid <= w_valid_nx;
      r_lock  <= w_lock_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_per_nx   = r_per;
    w_hi_nx    = r_hi;
    w_idle_nx  = r_idle;
    w_duty_nx  = r_duty;
    w_valid_nx = 1'b0;
    w_lock_nx  = r_lock;
    w_err_nx   = 1'b0;

    unique case (r_state)
      SEEK: begin
        w_per_nx = '0;
        w_hi_nx  = '0;
        if (r_rise) begin
          w_per_nx   = ONE;
          w_hi_nx    = ONE;
          w_state_nx = MEASURE;
        end
      end
      MEASURE: begin
        if (r_rise) begin
          if (r_per == PERIOD) begin
            w_duty_nx  = r_hi[CNT_W-1:0];
            w_valid_nx = 1'b1;
            w_lock_nx  = 1'b1;
          end else begin
            w_err_nx  = 1'b1;
            w_lock_nx = 1'b0;
          end
          w_per_nx = ONE;
          w_hi_nx  = ONE;
        end else if (r_per == PERIOD) begin
          // counter would pass a full period with no closing rise
          w_err_nx   = 1'b1;
          w_lock_nx  = 1'b0;
          w_per_nx   = '0;
          w_hi_nx    = '0;
          w_state_nx = SEEK;
        end else begin
          w_per_nx = w_per_inc;
          if (r_prev) w_hi_nx = w_hi_inc;
        end
      end
      default: w_state_nx = SEEK;
    endcase

    // static line: publish 0 or full scale every 2^CNT_W quiet cycles
    if (r_rise | r_fall) begin
      w_idle_nx = '0;
    end else if (r_idle == IDLE_TOP) begin
      w_idle_nx  = '0;
      w_duty_nx  = r_prev ? DUTY_MAX : '0;
      w_valid_nx = 1'b1;
      w_lock_nx  = ~w_err_nx;
    end else begin
      w_idle_nx = r_idle + 1'b1;
    end
  end

  assign duty_out   = r_duty;
  assign duty_valid = r_valid;
  assign locked     = r_lock;
  assign err        = r_err;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed bench for pwm_duty_decoder.
// Drives a phase-tracked PWM generator and checks published values.
module tb_pwm_duty_decoder;

  localparam int CW = 8;
  localparam int SS = 2;
`ifdef PWM_DEGLITCH_EN
  localparam int LAT = SS + 4;
  localparam int G_ERR = 0;
  localparam int G_LK = 1;
  localparam int G_DUTY = 50;
  localparam int G_Q = 2;
`else
  localparam int LAT = SS + 2;
  localparam int G_ERR = 2;
  localparam int G_LK = 0;
  localparam int G_DUTY = 100;
  localparam int G_Q = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] duty_out;
  logic          duty_valid;
  logic          locked;
  logic          err;

  pwm_duty_decoder #(
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .duty_valid(duty_valid),
    .locked    (locked),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int g_red = 100;
  int g_len = 256;
  int c_red = 100;
  int c_len = 256;
  int g_ph = 0;
  bit g_en = 1'b0;
  bit g_glitch = 1'b0;
  int t_rise = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (g_en) begin
      if (g_ph == 0) begin
        c_red  = g_red;
        c_len  = g_len;
        t_rise = cyc;
      end
      pwm_in   = (g_ph < c_red) || g_glitch;
      g_glitch = 1'b0;
      g_ph     = (g_ph + 1 >= c_len) ? 0 : g_ph + 1;
    end
  end

  logic [31:0] q[$];
  int e_cnt = 0;
  int n_both = 0;
  int last_lat = 0;
  int err_lat = 0;

  initial forever begin
    @(negedge clk);
    if (duty_valid === 1'b1) begin
      q.push_back(32'(duty_out));
      last_lat = cyc - t_rise;
    end
    if (err === 1'b1) begin
      e_cnt++;
      err_lat = cyc - t_rise;
    end
    if (duty_valid === 1'b1 && err === 1'b1) n_both++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    if (i < 0 || i >= q.size()) return 32'hFFFF_FFFF;
    return q[i];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic clr();
    q.delete();
    e_cnt  = 0;
    n_both = 0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_duty", 32'(duty_out), 0);
    chk("rst_valid", 32'(duty_valid), 0);
    chk("rst_lock", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    step(3);
    clr();
    g_en = 1'b1;

    step(4 * 256 + 10);
    chk("a_cnt", q.size(), 4);
    chk("a_first", qat(0), 100);
    chk("a_last", qat(3), 100);
    chk("a_lat", last_lat, LAT);
    chk("a_lock", 32'(locked), 1);
    chk("a_err", e_cnt, 0);
    clr();
    g_red = 110;

    step(256);
    g_red = 100;
    step(512);
    chk("b_cnt", q.size(), 3);
    chk("b_0", qat(0), 100);
    chk("b_1", qat(1), 110);
    chk("b_2", qat(2), 100);
    chk("b_err", e_cnt, 0);
    g_red = 50;

    step(396);
    clr();
    g_glitch = 1'b1;
    step(116);
    chk("g_err", e_cnt, G_ERR);
    chk("g_lock", 32'(locked), G_LK);
    chk("g_duty", 32'(duty_out), G_DUTY);
    step(256);
    chk("g_cnt", q.size(), G_Q);
    chk("g_val", qat(q.size() - 1), 50);
    chk("g_relock", 32'(locked), 1);
    clr();
    g_len = 200;

    step(256);
    g_len = 256;
    step(200);
    chk("s_err", e_cnt, 1);
    chk("s_lock", 32'(locked), 0);
    chk("s_duty", 32'(duty_out), 50);
    chk("s_cnt", q.size(), 1);
    clr();
    g_len = 300;

    step(256);
    g_len = 256;
    step(300);
    chk("o_err", e_cnt, 1);
    chk("o_lat", err_lat, 256 + LAT);
    chk("o_lock", 32'(locked), 0);
    chk("o_cnt", q.size(), 1);
    clr();
    g_red = 100;

    step(256);
    chk("o_rec_cnt", q.size(), 1);
    chk("o_rec_val", qat(0), 50);
    chk("o_rec_lock", 32'(locked), 1);
    step(256);
    chk("m_duty", 32'(duty_out), 100);

    step(110);
    rst_n = 1'b0;
    #1;
    chk("m_rst_duty", 32'(duty_out), 0);
    chk("m_rst_lock", 32'(locked), 0);
    chk("m_rst_valid", 32'(duty_valid), 0);
    chk("m_rst_err", 32'(err), 0);
    step(3);
    rst_n = 1'b1;
    clr();
    step(143);
    chk("m_none", q.size(), 0);
    step(256);
    chk("m_cnt", q.size(), 1);
    chk("m_val", qat(0), 100);
    chk("m_lock", 32'(locked), 1);

    rst_n = 1'b0;
    g_en = 1'b0;
    pwm_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    clr();
    step(600);
    chk("lo_cnt", q.size(), 2);
    chk("lo_0", qat(0), 0);
    chk("lo_1", qat(1), 0);
    chk("lo_err", e_cnt, 0);
    chk("lo_lock", 32'(locked), 1);

    clr();
    pwm_in = 1'b1;
    step(600);
    chk("hi_cnt", q.size(), 2);
    chk("hi_0", qat(0), 255);
    chk("hi_1", qat(1), 255);
    chk("hi_err", e_cnt, 1);
    chk("hi_both", n_both, 1);
    chk("hi_lock", 32'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
    $finish;
  end

endmodule
